// File: rtl/wishbone_pkg.sv
// Shared types and widths for the two-master pipelined Wishbone arbiter.
package wishbone_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Request fields forwarded from the owning master to the slave (69 bits).
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wishbone_arbiter_if.sv
// One pipelined Wishbone link. The master modport is the side that issues
// requests; the slave modport is the side that stalls, acks and returns data.
interface wishbone_arbiter_if;
  import wishbone_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_w;
  logic             stall;
  logic             ack;
  logic [DAT_W-1:0] dat_r;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  stall, ack, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output stall, ack, dat_r
  );

endinterface

// File: rtl/wishbone_outstanding_counter.sv
// Tracks requests accepted by the slave but not yet acknowledged.
// Saturates in both directions so it never wraps.
module wishbone_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inc,
  input  logic                                 dec,
  input  logic                                 clr,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count,
  output logic                                 full
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign count = count_q;

  // Next count: clear wins; simultaneous inc/dec cancel; stray dec at zero ignored.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter. A master owns the slave
// for as long as it holds CYC; ties from IDLE alternate using last_owner.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  wishbone_arbiter_if.slave  m0,
  wishbone_arbiter_if.slave  m1,
  wishbone_arbiter_if.master s
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       state_q, state_d;
  logic             last_owner_q, last_owner_d;

  logic [CNT_W-1:0] count;
  logic             full;
  logic             cnt_clr;
  logic             accept;

  wb_req_t          req0, req1, req_o;
  logic             own1;
  logic             own_cyc, own_stb;
  logic             cyc_o, stb_o;
  logic [1:0]       stall_o, ack_o;

  assign req0 = '{we: m0.we, adr: m0.adr, sel: m0.sel, dat: m0.dat_w};
  assign req1 = '{we: m1.we, adr: m1.adr, sel: m1.sel, dat: m1.dat_w};

  // Ownership FSM next state plus the owner's request/response muxing.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    own1         = (state_q == OWN1);
    own_cyc      = own1 ? m1.cyc : m0.cyc;
    own_stb      = own1 ? m1.stb : m0.stb;
    cyc_o        = 1'b0;
    stb_o        = 1'b0;
    req_o        = '0;
    stall_o      = 2'b11;
    ack_o        = 2'b00;
    accept       = 1'b0;
    cnt_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0.cyc && m1.cyc) begin
          // Contention: the master that did not own last time wins.
          if (last_owner_q) begin
            state_d      = OWN0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = OWN1;
            last_owner_d = 1'b1;
          end
        end else if (m0.cyc) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (m1.cyc) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0, OWN1: begin
        cyc_o = own_cyc;
        // STB is meaningless outside a cycle, so it is qualified with CYC too.
        stb_o = own_cyc && own_stb && !full;
        req_o = own1 ? req1 : req0;
        accept = stb_o && !s.stall;
        stall_o[own1] = s.stall || full;
        // An ACK with nothing outstanding (and nothing just accepted) is stray.
        ack_o[own1] = own_cyc && s.ack && ((count != '0) || accept);
        if (!own_cyc) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and arbitration history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  wishbone_outstanding_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_outstanding (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .dec  (s.ack),
    .clr  (cnt_clr),
    .count(count),
    .full (full)
  );

  assign s.cyc   = cyc_o;
  assign s.stb   = stb_o;
  assign s.we    = req_o.we;
  assign s.adr   = req_o.adr;
  assign s.sel   = req_o.sel;
  assign s.dat_w = req_o.dat;

  assign m0.stall = stall_o[0];
  assign m0.ack   = ack_o[0];
  assign m0.dat_r = s.dat_r;
  assign m1.stall = stall_o[1];
  assign m1.ack   = ack_o[1];
  assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed vector bench for wishbone_arbiter (MAX_OUTSTANDING = 4).
module tb_wishbone_arbiter;

  logic clk = 1'b0;
  logic rst;

  wishbone_arbiter_if m0_if ();
  wishbone_arbiter_if m1_if ();
  wishbone_arbiter_if s_if ();

  wishbone_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk),
    .rst(rst),
    .m0 (m0_if.slave),
    .m1 (m1_if.slave),
    .s  (s_if.master)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] M0_DAT = 32'hDEADBEEF;
  localparam logic [3:0]  M0_SEL = 4'hF;
  localparam logic [31:0] M1_DAT = 32'h12345678;
  localparam logic [3:0]  M1_SEL = 4'h3;

  // in_f = {rst, m0 cyc,stb,we, m1 cyc,stb, s stall,ack}
  // ex_f = {s cyc,stb,we, m0 stall,ack, m1 stall,ack}
  // own  = 0 none, 1 m0, 2 m1 (selects expected s_SEL/s_DAT)
  typedef struct {
    string       name;
    logic [7:0]  in_f;
    logic [31:0] m0_adr;
    logic [31:0] m1_adr;
    logic [1:0]  own;
    logic [6:0]  ex_f;
    logic [31:0] e_adr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  string cur;

  function automatic vec_t mk(input string n, input logic [7:0] i, input logic [31:0] a0,
                              input logic [31:0] a1, input logic [1:0] o, input logic [6:0] e,
                              input logic [31:0] ea);
    vec_t v;
    v.name = n; v.in_f = i; v.m0_adr = a0; v.m1_adr = a1; v.own = o; v.ex_f = e; v.e_adr = ea;
    return v;
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, what, act, exp);
    end
  endtask

  task automatic drive_idle();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.adr = '0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.adr = '0;
    s_if.stall = 1'b0; s_if.ack = 1'b0; s_if.dat_r = '0;
  endtask

  initial begin
    int accepts;
    bit granted;

    m0_if.sel = M0_SEL; m0_if.dat_w = M0_DAT;
    m1_if.sel = M1_SEL; m1_if.dat_w = M1_DAT;
    drive_idle();
    rst = 1'b1;

    //                name              rst m0  m1 ss      m0a      m1a      own  ex            e_adr
    vecs.push_back(mk("idle_after_rst", 8'b0_000_00_00, 32'h0,   32'h0,   2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("tie_req",        8'b0_100_10_00, 32'h200, 32'h300, 2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("tie_own0",       8'b0_100_10_00, 32'h200, 32'h300, 2'd1, 7'b100_00_10, 32'h200));
    vecs.push_back(mk("m0_drop",        8'b0_000_10_00, 32'h0,   32'h300, 2'd1, 7'b000_00_10, 32'h0));
    vecs.push_back(mk("idle_gap",       8'b0_000_10_00, 32'h0,   32'h300, 2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("own1",           8'b0_000_10_00, 32'h0,   32'h300, 2'd2, 7'b100_10_00, 32'h300));
    vecs.push_back(mk("nonowner_noise", 8'b0_111_10_00, 32'h999, 32'h300, 2'd2, 7'b100_10_00, 32'h300));
    vecs.push_back(mk("m1_drop",        8'b0_100_00_00, 32'h200, 32'h0,   2'd2, 7'b000_10_00, 32'h0));
    vecs.push_back(mk("idle_tie2",      8'b0_100_10_00, 32'h200, 32'h300, 2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("tie2_own0",      8'b0_100_10_00, 32'h200, 32'h300, 2'd1, 7'b100_00_10, 32'h200));
    vecs.push_back(mk("m0_drop2",       8'b0_000_10_00, 32'h0,   32'h300, 2'd1, 7'b000_00_10, 32'h0));
    vecs.push_back(mk("idle_tie3",      8'b0_100_10_00, 32'h200, 32'h300, 2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("tie3_own1",      8'b0_100_10_00, 32'h200, 32'h300, 2'd2, 7'b100_10_00, 32'h300));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk($sformatf("rd%0d", k), 8'b0_000_11_00, 32'h0, 32'h300, 2'd2, 7'b110_10_00, 32'h300));
    vecs.push_back(mk("full_hold",      8'b0_000_11_00, 32'h0,   32'h300, 2'd2, 7'b100_10_10, 32'h300));
    vecs.push_back(mk("full_ack",       8'b0_000_11_01, 32'h0,   32'h300, 2'd2, 7'b100_10_11, 32'h300));
    vecs.push_back(mk("rd5_accept",     8'b0_000_11_00, 32'h0,   32'h300, 2'd2, 7'b110_10_00, 32'h300));
    vecs.push_back(mk("full_again",     8'b0_000_11_00, 32'h0,   32'h300, 2'd2, 7'b100_10_10, 32'h300));
    vecs.push_back(mk("stall_ack",      8'b0_000_10_11, 32'h0,   32'h300, 2'd2, 7'b100_10_11, 32'h300));
    vecs.push_back(mk("stall_pass",     8'b0_000_11_10, 32'h0,   32'h300, 2'd2, 7'b110_10_10, 32'h300));
    vecs.push_back(mk("rst_mid_own1",   8'b1_000_10_00, 32'h0,   32'h300, 2'd2, 7'b100_10_00, 32'h300));
    vecs.push_back(mk("rst_idle",       8'b0_000_10_00, 32'h0,   32'h300, 2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("late_ack_drop",  8'b0_000_10_01, 32'h0,   32'h300, 2'd2, 7'b100_10_00, 32'h300));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk($sformatf("rr%0d", k), 8'b0_000_11_00, 32'h0, 32'h300, 2'd2, 7'b110_10_00, 32'h300));
    vecs.push_back(mk("rr_full",        8'b0_000_11_00, 32'h0,   32'h300, 2'd2, 7'b100_10_10, 32'h300));
    vecs.push_back(mk("m1_abort_full",  8'b0_000_00_00, 32'h0,   32'h0,   2'd2, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("idle_m0_req",    8'b0_111_00_00, 32'h100, 32'h0,   2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("wr_accept",      8'b0_111_00_00, 32'h100, 32'h0,   2'd1, 7'b111_00_10, 32'h100));
    vecs.push_back(mk("wr_ack",         8'b0_101_00_01, 32'h100, 32'h0,   2'd1, 7'b101_01_10, 32'h100));
    vecs.push_back(mk("wr2",            8'b0_111_00_00, 32'h100, 32'h0,   2'd1, 7'b111_00_10, 32'h100));
    vecs.push_back(mk("wr3",            8'b0_111_00_00, 32'h100, 32'h0,   2'd1, 7'b111_00_10, 32'h100));
    vecs.push_back(mk("m0_abort_2out",  8'b0_000_00_00, 32'h0,   32'h0,   2'd1, 7'b000_00_10, 32'h0));
    vecs.push_back(mk("stray_ack_idle", 8'b0_000_00_01, 32'h0,   32'h0,   2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("regrant_m0",     8'b0_100_00_00, 32'h100, 32'h0,   2'd0, 7'b000_10_10, 32'h0));
    vecs.push_back(mk("ack_after_clr",  8'b0_100_00_01, 32'h100, 32'h0,   2'd1, 7'b100_00_10, 32'h100));
    vecs.push_back(mk("m0_end",         8'b0_000_00_00, 32'h0,   32'h0,   2'd1, 7'b000_00_10, 32'h0));
    vecs.push_back(mk("idle_end",       8'b0_000_00_00, 32'h0,   32'h0,   2'd0, 7'b000_10_10, 32'h0));

    // Reset for two edges, then one vector per cycle.
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      logic [31:0] sdat;
      int err_before;
      sdat = 32'hA500_0000 | 32'(i);
      cur = vecs[i].name;
      err_before = errors;
      rst        = vecs[i].in_f[7];
      m0_if.cyc  = vecs[i].in_f[6];
      m0_if.stb  = vecs[i].in_f[5];
      m0_if.we   = vecs[i].in_f[4];
      m1_if.cyc  = vecs[i].in_f[3];
      m1_if.stb  = vecs[i].in_f[2];
      m1_if.we   = 1'b0;
      s_if.stall = vecs[i].in_f[1];
      s_if.ack   = vecs[i].in_f[0];
      m0_if.adr  = vecs[i].m0_adr;
      m1_if.adr  = vecs[i].m1_adr;
      s_if.dat_r = sdat;
      @(negedge clk);
      chk("s_cyc",    32'(s_if.cyc),    32'(vecs[i].ex_f[6]));
      chk("s_stb",    32'(s_if.stb),    32'(vecs[i].ex_f[5]));
      chk("s_we",     32'(s_if.we),     32'(vecs[i].ex_f[4]));
      chk("m0_stall", 32'(m0_if.stall), 32'(vecs[i].ex_f[3]));
      chk("m0_ack",   32'(m0_if.ack),   32'(vecs[i].ex_f[2]));
      chk("m1_stall", 32'(m1_if.stall), 32'(vecs[i].ex_f[1]));
      chk("m1_ack",   32'(m1_if.ack),   32'(vecs[i].ex_f[0]));
      chk("s_adr",    s_if.adr,         vecs[i].e_adr);
      chk("m0_dat",   m0_if.dat_r,      sdat);
      chk("m1_dat",   m1_if.dat_r,      sdat);
      if (vecs[i].own == 2'd1) begin
        chk("s_sel", 32'(s_if.sel), 32'(M0_SEL));
        chk("s_dat", s_if.dat_w,    M0_DAT);
      end else if (vecs[i].own == 2'd2) begin
        chk("s_sel", 32'(s_if.sel), 32'(M1_SEL));
        chk("s_dat", s_if.dat_w,    M1_DAT);
      end
      $display("vec %0d %-16s errors_in_vec=%0d", i, vecs[i].name, errors - err_before);
      @(posedge clk);
      #1;
    end

    // Hand-written: m1 streams reads into a silent slave; exactly four accepted.
    cur = "stream6";
    drive_idle();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h400;
    granted = 1'b0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      if (!m1_if.stall) begin
        granted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("grant_within_budget", 32'(granted), 32'd1);
    accepts = 0;
    for (int k = 0; k < 6; k++) begin
      if (s_if.stb && !s_if.stall) accepts++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk("accepted_count", 32'(accepts), 32'd4);
    chk("full_s_stb",     32'(s_if.stb),     32'd0);
    chk("full_m1_stall",  32'(m1_if.stall),  32'd1);
    $display("seq stream6 accepts=%0d", accepts);

    @(posedge clk); #1;
    s_if.ack = 1'b1;
    @(negedge clk);
    chk("one_ack_fwd", 32'(m1_if.ack), 32'd1);
    chk("one_ack_m0",  32'(m0_if.ack), 32'd0);
    @(posedge clk); #1;
    s_if.ack = 1'b0;
    @(negedge clk);
    chk("fifth_s_stb",    32'(s_if.stb),    32'd1);
    chk("fifth_m1_stall", 32'(m1_if.stall), 32'd0);
    chk("fifth_s_adr",    s_if.adr,         32'h400);
    $display("seq ack_then_fifth m1_stall=%0b s_stb=%0b", m1_if.stall, s_if.stb);

    @(posedge clk); #1;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    @(negedge clk);
    chk("drop_s_cyc", 32'(s_if.cyc), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("final_m0_stall", 32'(m0_if.stall), 32'd1);
    chk("final_m1_stall", 32'(m1_if.stall), 32'd1);
    $display("seq release s_cyc=%0b", s_if.cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_OUTSTANDING, default 4, maximum accepted-but-unacknowledged slave requests (1..15).
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset; synchronous, active-high.
REQ-004 m0_CYC_I / m1_CYC_I  in  1  master bus-cycle request.
REQ-005 m0_STB_I / m1_STB_I  in  1  master strobe, pipelined mode.
REQ-006 m0_WE_I / m1_WE_I  in  1  write enable.
REQ-007 m0_ADR_I / m1_ADR_I  in  32  address.
REQ-008 m0_SEL_I / m1_SEL_I  in  4  byte selects.
REQ-009 m0_DAT_I / m1_DAT_I  in  32  write data.
REQ-010 m0_STALL_O / m1_STALL_O  out  1  stall to master.
REQ-011 m0_ACK_O / m1_ACK_O  out  1  acknowledge to master.
REQ-012 m0_DAT_O / m1_DAT_O  out  32  read data to master.
REQ-013 s_CYC_O, s_STB_O, s_WE_O  out  1 each  slave cycle, strobe, write enable.
REQ-014 s_ADR_O  out  32;  s_SEL_O  out  4;  s_DAT_O  out  32  slave request fields.
REQ-015 s_STALL_I, s_ACK_I  in  1 each;  s_DAT_I  in  32  slave responses.

Function
REQ-016 States: IDLE, OWN0, OWN1; registered; the owner's request mux drives all s_* request outputs.
REQ-017 IDLE: all s_CYC_O/s_STB_O = 0; both mN_STALL_O = 1; both mN_ACK_O = 0.
REQ-018 IDLE, exactly one mN_CYC_I = 1 -> OWNn next cycle.
REQ-019 IDLE, both CYC_I = 1 -> grant master != last_owner; last_owner updates on every grant.
REQ-020 OWNn: s_CYC_O = mn_CYC_I; s_STB_O = mn_STB_I && !full; mn_STALL_O = s_STALL_I || full; other master STALL_O = 1, ACK_O = 0.
REQ-021 OWNn: mn_ACK_O = s_ACK_I && mn_CYC_I; mN_DAT_O = s_DAT_I for both masters (qualified by ACK only).
REQ-022 Outstanding counter, width clog2(MAX_OUTSTANDING+1): +1 on s_STB_O && !s_STALL_I; -1 on s_ACK_I; both same cycle -> unchanged; never wraps.
REQ-023 full = (count == MAX_OUTSTANDING); when full, s_STB_O forced 0 regardless of owner STB.
REQ-024 OWNn and mn_CYC_I = 0 -> IDLE next cycle, counter cleared to 0 (abort; s_CYC_O falls same cycle).
REQ-025 Ownership never changes while owner CYC_I = 1; no timeout pre-emption.
REQ-026 Minimum one IDLE cycle between consecutive ownerships; back-to-back re-grant to same master permitted if the other is idle.
REQ-027 s_ACK_I with count == 0 and no same-cycle accepted STB SHALL be dropped (not forwarded); counter stays 0.
REQ-028 Non-owner STB_I/ADR_I changes SHALL have no effect on any s_* output.

Reset
REQ-029 RST = 1 at a clock edge -> state IDLE, counter 0, last_owner = 1 (m0 wins first contention); outputs per REQ-017 from the following cycle.
REQ-030 RST asserted mid-transaction SHALL abandon it; s_CYC_O = 0 the cycle after the reset edge, late slave ACKs dropped per REQ-027.

Structure
REQ-031 Shared package wishbone_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), the request struct (we, adr, sel, dat = 69 bits) and ADR/DAT/SEL width constants.
REQ-032 One sub-module, wishbone_outstanding_counter (inc, dec, clr, count, full), parameterised by MAX_OUTSTANDING.

Verification
REQ-033 m0 CYC/STB write ADR=0x100 SEL=0xF DAT=0xDEADBEEF, slave no stall, ACK 1 cycle later -> OWN0 one cycle after CYC, s_ADR_O=0x100, m0_ACK_O=1, m1 stalled throughout.
REQ-034 m0 and m1 raise CYC same cycle after reset -> m0 owns first; m0 drops CYC -> IDLE, then OWN1; next tie -> m0 again.
REQ-035 MAX_OUTSTANDING=4, m1 issues 6 reads, slave never ACKs -> exactly 4 accepted, s_STB_O=0 and m1_STALL_O=1 after 4th; one ACK -> 5th accepted.
REQ-036 m0 drops CYC with 2 outstanding -> s_CYC_O=0 same cycle, counter 0, IDLE next cycle; stray s_ACK_I=1 afterwards -> no mN_ACK_O.
REQ-037 RST pulsed while OWN1 with count 3 -> IDLE, count 0, s_CYC_O=0 next cycle; m1 holding CYC re-granted after one IDLE cycle.
REQ-038 Formal bench SHALL bind the pipelined Wishbone master/slave property checkers to each port and prove count <= MAX_OUTSTANDING and no ACK to a non-owner.
